// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed/unsigned, start/busy/done handshake
// Quotient goes to the low half of z_out, remainder to the high half.
module seq_divider #(
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic [2*WIDTH-1:0] z_out,
   output logic               div_by_zero
);
   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
   state_t           state, state_nxt;
   logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
   logic [CNT_W-1:0] cnt;
   logic             q_neg, r_neg, dz_r;
   logic             dvd_neg, dvs_neg;
   logic [WIDTH:0]   shifted, trial;

   assign dvd_neg = signed_mode & dividend[WIDTH-1];
   assign dvs_neg = signed_mode & divisor[WIDTH-1];
   // partial remainder stays below the divisor, so bit WIDTH of the trial is its sign
   assign shifted = {rem_r, quo_r[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_r};
   assign z_out   = {remainder, quotient};

   always_ff @(posedge clock)
      state <= !clear ? IDLE : state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? (divisor == '0 ? DONE : CALC) : IDLE;
         CALC:    state_nxt = cnt == CNT_W'(WIDTH - 1) ? FIXUP : CALC;
         FIXUP:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         rem_r       <= '0;
         quo_r       <= '0;
         dvs_r       <= '0;
         cnt         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         dz_r        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               busy        <= 1'b1;
               div_by_zero <= 1'b0;
               cnt         <= '0;
               rem_r       <= '0;
               dvs_r       <= dvs_neg ? -divisor : divisor;
               // a zero divisor keeps the raw dividend so it can be returned untouched
               quo_r       <= (dvd_neg && divisor != '0) ? -dividend : dividend;
               q_neg       <= dvd_neg ^ dvs_neg;
               r_neg       <= dvd_neg;
               dz_r        <= divisor == '0;
            end
            CALC: begin
               rem_r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
               quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
               cnt   <= cnt + 1'b1;
            end
            FIXUP: begin
               quotient  <= q_neg ? -quo_r : quo_r;
               remainder <= r_neg ? -rem_r : rem_r;
            end
            DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
               if (dz_r) begin
                  quotient    <= '1;
                  remainder   <= quo_r;
                  div_by_zero <= 1'b1;
               end
            end
            default: busy <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scenario tasks checking seq_divider against an arithmetic reference model
module tb_seq_divider;
   logic        clock = 0, clear = 0, start = 0, signed_mode = 0;
   logic [31:0] dividend = 0, divisor = 0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;
   logic [63:0] z_out;
   logic        start8 = 0;
   logic [7:0]  dvd8 = 0, dvs8 = 0;
   logic        busy8, done8, dz8;
   logic [7:0]  q8, r8;
   logic [15:0] z8;
   int          passed = 0, total = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clock(clock), .clear(clear), .start(start), .signed_mode(signed_mode),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .z_out(z_out), .div_by_zero(div_by_zero)
   );

   seq_divider #(.WIDTH(8)) dut8 (
      .clock(clock), .clear(clear), .start(start8), .signed_mode(signed_mode),
      .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
      .quotient(q8), .remainder(r8), .z_out(z8), .div_by_zero(dz8)
   );

   always #5 clock = ~clock;

   function automatic void model(input logic sm, input logic [31:0] a, b,
                                 output logic [31:0] q, r, output logic dz);
      longint sa, sb;
      dz = (b == 0);
      if (dz) begin
         q = '1;
         r = a;
      end else if (sm) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic launch(input logic sm, input logic [31:0] a, b);
      @(negedge clock);
      signed_mode = sm; dividend = a; divisor = b; start = 1;
      @(posedge clock); #1;
      start = 0;
   endtask

   task automatic wait_done(output int lat, output int bc);
      lat = -1;
      bc = busy ? 1 : 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clock); #1;
         if (done) begin lat = n; break; end
         if (busy) bc++;
      end
   endtask

   task automatic test_reset;
      clear = 0;
      repeat (2) @(posedge clock);
      #1;
      total++; if ({busy, done, div_by_zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); else passed++;
      total++; if (z_out !== 64'h0 || quotient !== 32'h0 || remainder !== 32'h0) $display("FAIL reset_data got z=%h want 0", z_out); else passed++;
      total++; if ({busy8, done8, dz8, z8} !== 19'h0) $display("FAIL reset_w8 got %h want 0", {busy8, done8, dz8, z8}); else passed++;
      @(negedge clock);
      clear = 1;
   endtask

   task automatic test_vectors;
      logic        sm [7] = '{1, 0, 1, 1, 0, 1, 0};
      logic [31:0] a  [7] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'd30, 32'hFFFFFFE2, 32'd123, 32'h80000000, 32'd1000};
      logic [31:0] b  [7] = '{32'd25, 32'd25, 32'hFFFFFFF9, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd10};
      logic [31:0] eq [7] = '{32'h0, 32'h0A3D70A3, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h80000000, 32'd100};
      logic [31:0] er [7] = '{32'hFFFFFFFB, 32'd16, 32'd2, 32'hFFFFFFFE, 32'd123, 32'h0, 32'd0};
      logic        ed [7] = '{0, 0, 0, 0, 1, 0, 0};
      int lat, bc, el;
      for (int i = 0; i < 7; i++) begin
         launch(sm[i], a[i], b[i]);
         wait_done(lat, bc);
         el = ed[i] ? 1 : 34;
         total++; if (lat !== el) $display("FAIL vec%0d_latency got %0d want %0d", i, lat, el); else passed++;
         total++; if (bc !== el) $display("FAIL vec%0d_busy_cycles got %0d want %0d", i, bc, el); else passed++;
         total++; if (busy !== 1'b0) $display("FAIL vec%0d_busy_at_done got %b want 0", i, busy); else passed++;
         total++; if (quotient !== eq[i] || remainder !== er[i]) $display("FAIL vec%0d_result got q=%h r=%h want q=%h r=%h", i, quotient, remainder, eq[i], er[i]); else passed++;
         total++; if (z_out !== {er[i], eq[i]}) $display("FAIL vec%0d_z_out got %h want %h", i, z_out, {er[i], eq[i]}); else passed++;
         total++; if (div_by_zero !== ed[i]) $display("FAIL vec%0d_dbz got %b want %b", i, div_by_zero, ed[i]); else passed++;
         @(posedge clock); #1;
         total++; if (done !== 1'b0) $display("FAIL vec%0d_done_pulse got %b want 0", i, done); else passed++;
      end
   endtask

   task automatic test_random;
      logic        sm, dz;
      logic [31:0] a, b, q, r;
      int lat, bc;
      for (int i = 0; i < 24; i++) begin
         sm = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 0;
            1: b = $urandom_range(1, 15);
            2: b = 32'hFFFFFFFF - $urandom_range(0, 9);
            default: b = $urandom;
         endcase
         model(sm, a, b, q, r, dz);
         launch(sm, a, b);
         wait_done(lat, bc);
         total++; if (lat !== (dz ? 1 : 34)) $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, dz ? 1 : 34); else passed++;
         total++; if ({quotient, remainder, div_by_zero} !== {q, r, dz}) $display("FAIL rnd%0d_result sm=%b a=%h b=%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i, sm, a, b, quotient, remainder, div_by_zero, q, r, dz); else passed++;
      end
   endtask

   task automatic test_ignore_start;
      int lat, bc;
      launch(0, 32'd1000, 32'd7);
      repeat (9) @(posedge clock);
      @(negedge clock);
      start = 1; signed_mode = 1; dividend = 32'd5; divisor = 32'd1;
      @(posedge clock); #1;
      start = 0;
      wait_done(lat, bc);
      total++; if (lat !== 24) $display("FAIL ignore_latency got %0d want 24", lat); else passed++;
      total++; if (quotient !== 32'd142 || remainder !== 32'd6) $display("FAIL ignore_result got q=%0d r=%0d want q=142 r=6", quotient, remainder); else passed++;
   endtask

   task automatic test_clear_mid;
      logic seen = 0;
      launch(1, 32'hFFFF0000, 32'd3);
      repeat (14) @(posedge clock);
      @(negedge clock);
      clear = 0;
      @(posedge clock); #1;
      total++; if ({busy, done, div_by_zero, z_out} !== 67'h0) $display("FAIL clear_mid_outputs got busy=%b z=%h want 0", busy, z_out); else passed++;
      @(negedge clock);
      clear = 1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clock); #1;
         if (done || busy) seen = 1;
      end
      total++; if (seen !== 1'b0) $display("FAIL clear_mid_no_done got %b want 0", seen); else passed++;
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      @(negedge clock);
      signed_mode = 0; dividend = 32'd100; divisor = 32'd9; start = 1;
      @(posedge clock); #1;
      dividend = 32'd77; divisor = 32'd5;
      wait_done(lat, bc);
      total++; if (lat !== 34 || quotient !== 32'd11 || remainder !== 32'd1) $display("FAIL b2b_first got lat=%0d q=%0d r=%0d want 34 11 1", lat, quotient, remainder); else passed++;
      @(posedge clock); #1;
      start = 0;
      total++; if (busy !== 1'b1) $display("FAIL b2b_reaccept got busy=%b want 1", busy); else passed++;
      wait_done(lat, bc);
      total++; if (lat !== 34 || quotient !== 32'd15 || remainder !== 32'd2) $display("FAIL b2b_second got lat=%0d q=%0d r=%0d want 34 15 2", lat, quotient, remainder); else passed++;
   endtask

   task automatic test_width8;
      logic        sm [2] = '{0, 1};
      logic [7:0]  a  [2] = '{8'd200, 8'h9C};
      logic [7:0]  b  [2] = '{8'd7, 8'd7};
      logic [7:0]  eq [2] = '{8'd28, 8'hF2};
      logic [7:0]  er [2] = '{8'd4, 8'hFE};
      int lat;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         signed_mode = sm[i]; dvd8 = a[i]; dvs8 = b[i]; start8 = 1;
         @(posedge clock); #1;
         start8 = 0;
         lat = -1;
         for (int n = 1; n <= 50; n++) begin
            @(posedge clock); #1;
            if (done8) begin lat = n; break; end
         end
         total++; if (lat !== 10) $display("FAIL w8_%0d_latency got %0d want 10", i, lat); else passed++;
         total++; if (z8 !== {er[i], eq[i]} || dz8 !== 1'b0) $display("FAIL w8_%0d_result got z=%h dz=%b want z=%h dz=0", i, z8, dz8, {er[i], eq[i]}); else passed++;
      end
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_random;
      test_ignore_start;
      test_clear_mid;
      test_back_to_back;
      test_width8;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
